// File: rtl/uram_stream_reader_pkg.sv
// Shared types for the URAM stream reader: FSM encoding and output FIFO sizing.
// The FIFO depth is also the read credit pool, so the two must stay in lock-step.
package uram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_AW    = $clog2(FIFO_DEPTH);
    localparam int FIFO_CW    = FIFO_AW + 1;

endpackage

// File: rtl/uram_stream_reader_fifo4.sv
// 4-entry synchronous FIFO with occupancy count; head is visible the cycle after push.
// Backpressure: push is dropped when full (upstream credit keeps that from happening).
module stream_fifo4
    import uram_stream_reader_pkg::*;
#(
    parameter int W = 73
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_push,
    input  logic [W-1:0]       i_dat,
    input  logic               i_pop,
    output logic               o_vld,
    output logic [W-1:0]       o_dat,
    output logic [FIFO_CW-1:0] o_count
);

    logic [W-1:0]       r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_CW-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push  = i_push && (r_count != FIFO_CW'(FIFO_DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_vld   = (r_count != '0);
    assign o_dat   = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage is reset too so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_dat;
                r_wr_ptr        <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FIFO_CW'(1);
                2'b01:   r_count <= r_count - FIFO_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uram_stream_reader.sv
// Sequential URAM reader: (base,len) command -> valid/ready stream with last; first beat 3 cycles after start.
// Backpressure: reads issue only while FIFO count + in-flight reads < FIFO depth, so stalls never lose data.
module uram_stream_reader
    import uram_stream_reader_pkg::*;
#(
    parameter int AWIDTH  = 10,
    parameter int NUM_COL = 9,
    parameter int DWIDTH  = 72
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [AWIDTH-1:0]  base_addr,
    input  logic [AWIDTH:0]    len,
    output logic               busy,
    output logic               done,
    output logic [NUM_COL-1:0] mem_we,
    output logic [DWIDTH-1:0]  mem_din,
    output logic [AWIDTH-1:0]  mem_addr,
    input  logic [DWIDTH-1:0]  mem_dout,
    output logic [DWIDTH-1:0]  m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last
);

    localparam logic [AWIDTH:0] LEN_ONE = {{AWIDTH{1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AWIDTH-1:0]   r_addr;
    logic [AWIDTH-1:0]   r_mem_addr;
    logic [AWIDTH:0]     r_rem;
    logic [1:0]          r_pipe_vld;
    logic [1:0]          r_pipe_last;
    logic [AWIDTH-1:0]   w_iss_addr;
    logic [AWIDTH:0]     w_iss_rem;
    logic                w_accept;
    logic                w_issue;
    logic                w_credit;
    logic [FIFO_CW-1:0]  w_inflight;
    logic [FIFO_CW-1:0]  w_fifo_cnt;
    logic                w_fifo_vld;
    logic [DWIDTH:0]     w_fifo_dat;
    logic                w_pop;

    // The accepting cycle issues the first read straight from the command inputs,
    // which saves a cycle of start-up latency.
    always_comb begin
        w_inflight  = FIFO_CW'(r_pipe_vld[0]) + FIFO_CW'(r_pipe_vld[1]);
        w_credit    = (w_fifo_cnt + w_inflight) < FIFO_CW'(FIFO_DEPTH);
        w_accept    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_iss_addr  = w_accept ? base_addr : r_addr;
        w_iss_rem   = w_accept ? len : r_rem;
        w_issue     = w_credit && (w_accept || (r_state == ST_RUN)) && (w_iss_rem != '0);
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    if (len == '0)                     w_state_nxt = ST_DONE;
                    else if (w_issue && len == LEN_ONE) w_state_nxt = ST_DRAIN;
                    else                               w_state_nxt = ST_RUN;
                end else if (r_state == ST_DONE) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN:   if (w_issue && r_rem == LEN_ONE) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_pop && m_last)             w_state_nxt = ST_DONE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_mem_addr  <= '0;
            r_rem       <= '0;
            r_pipe_vld  <= '0;
            r_pipe_last <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pipe_vld  <= {r_pipe_vld[0], w_issue};
            r_pipe_last <= {r_pipe_last[0], w_issue && (w_iss_rem == LEN_ONE)};
            if (w_issue) begin
                r_mem_addr <= w_iss_addr;
                r_addr     <= w_iss_addr + AWIDTH'(1);
                r_rem      <= w_iss_rem - LEN_ONE;
            end else if (w_accept) begin
                r_addr <= base_addr;
                r_rem  <= len;
            end
        end
    end

    // Stage 1 of the pipe is the cycle the URAM output register holds the word.
    stream_fifo4 #(
        .W (DWIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (r_pipe_vld[1]),
        .i_dat   ({r_pipe_last[1], mem_dout}),
        .i_pop   (w_pop),
        .o_vld   (w_fifo_vld),
        .o_dat   (w_fifo_dat),
        .o_count (w_fifo_cnt)
    );

    assign w_pop    = m_valid && m_ready;
    assign m_valid  = w_fifo_vld;
    assign m_data   = w_fifo_dat[DWIDTH-1:0];
    assign m_last   = w_fifo_vld && w_fifo_dat[DWIDTH];
    assign busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done     = (r_state == ST_DONE);
    assign mem_we   = '0;
    assign mem_din  = '0;
    assign mem_addr = r_mem_addr;

endmodule

// File: tb/tb_uram_stream_reader.sv
// Bench for uram_stream_reader: URAM behavioural model, expected-beat queue and cycle-accurate done/busy model.
module tb_uram_stream_reader;

    localparam int AW    = 10;
    localparam int NC    = 9;
    localparam int DW    = 72;
    localparam int LW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int NEVER = 32'h7fffffff;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] dat;
    } beat_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   len = '0;
    logic          m_ready = 1'b1;
    logic          busy, done, m_valid, m_last;
    logic [NC-1:0] mem_we;
    logic [DW-1:0] mem_din, mem_dout, m_data;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] mem_rd = '0;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    beat_t exp_q[$];
    int    done_q[$];
    int    beat_cyc[$];
    int    idle_from = 0;
    int    busy_from = 0;
    int    beats_seen = 0;
    int    last_done_cyc = -1;
    logic  rdy_rand = 1'b0;

    uram_stream_reader #(.AWIDTH(AW), .NUM_COL(NC), .DWIDTH(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .mem_we    (mem_we),
        .mem_din   (mem_din),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // URAM port: registered read, output register updates only with all write enables low.
    always @(posedge clk) if (mem_we == '0) mem_rd <= mem[mem_addr];
    assign mem_dout = mem_rd;

    always @(posedge clk) begin
        #1;
        m_ready = rdy_rand ? 1'($urandom) : 1'b1;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        beat_t e;
        logic  exp_done;
        if (rstn) begin
            exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
            if (exp_done) void'(done_q.pop_front());
            check_eq("busy", 128'(busy), 128'((cyc >= busy_from) && (cyc < idle_from)));
            check_eq("done", 128'(done), 128'(exp_done));
            if (done) last_done_cyc = cyc;
            check_eq("mem_we", 128'(mem_we), 128'(0));
            check_eq("mem_din", 128'(mem_din), 128'(0));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", 128'(m_valid), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("beat_data", 128'(m_data), 128'(e.dat));
                    check_eq("beat_last", 128'(m_last), 128'(e.last));
                    beats_seen++;
                    beat_cyc.push_back(cyc);
                    if (e.last) begin
                        idle_from = cyc + 1;
                        done_q.push_back(cyc + 1);
                    end
                end
            end
        end
    end

    // Held beat must not change while the consumer stalls.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_dat = '0;
    logic          prev_last = 1'b0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", 128'(m_valid), 128'(1));
                check_eq("stall_data", 128'(m_data), 128'(prev_dat));
                check_eq("stall_last", 128'(m_last), 128'(prev_last));
            end
            prev_stall = m_valid && !m_ready;
            prev_dat   = m_data;
            prev_last  = m_last;
        end
    end

    task automatic do_start(input int b, input int l, output int c);
        @(posedge clk); #1;
        base_addr = AW'(b);
        len       = LW'(l);
        start     = 1'b1;
        c         = cyc;
        if (cyc >= idle_from) begin
            for (int i = 0; i < l; i++) begin
                beat_t e;
                e.dat  = mem[(b + i) % DEPTH];
                e.last = (i == l - 1);
                exp_q.push_back(e);
            end
            busy_from = cyc + 1;
            if (l == 0) begin
                idle_from = cyc + 1;
                done_q.push_back(cyc + 1);
            end else begin
                idle_from = NEVER;
            end
        end
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        len       = LW'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((cyc < idle_from || exp_q.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("idle_within_budget", 128'(n < budget), 128'(1));
    endtask

    task automatic wait_beats(input int tgt, input int budget);
        int n = 0;
        while (beats_seen < tgt && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq("beats_within_budget", 128'(beats_seen), 128'(tgt));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c, c2, a0, n;
        for (int i = 0; i < DEPTH; i++) mem[i] = {32'($urandom), 30'($urandom), AW'(i)};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_done", 128'(done), 128'(0));
        check_eq("rst_valid", 128'(m_valid), 128'(0));
        check_eq("rst_last", 128'(m_last), 128'(0));
        check_eq("rst_data", 128'(m_data), 128'(0));
        check_eq("rst_addr", 128'(mem_addr), 128'(0));
        rstn = 1'b1;

        // Directed latency/throughput: base 0x010, len 4
        beat_cyc.delete();
        do_start(32'h010, 4, c);
        wait_idle(50);
        @(negedge clk); #1;
        check_eq("t1_nbeats", 128'(beat_cyc.size()), 128'(4));
        check_eq("t1_first_cyc", 128'(beat_cyc[0]), 128'(c + 3));
        check_eq("t1_last_cyc", 128'(beat_cyc[3]), 128'(c + 6));
        check_eq("t1_done_cyc", 128'(last_done_cyc), 128'(c + 7));

        // Address wrap 0x3FC..0x003
        beat_cyc.delete();
        do_start(32'h3FC, 8, c);
        wait_idle(60);
        check_eq("t2_nbeats", 128'(beat_cyc.size()), 128'(8));

        // Random backpressure, len 16
        beat_cyc.delete();
        rdy_rand = 1'b1;
        do_start(int'($urandom_range(0, DEPTH - 1)), 16, c);
        wait_idle(400);
        rdy_rand = 1'b0;
        check_eq("t3_nbeats", 128'(beat_cyc.size()), 128'(16));

        // Zero length
        beat_cyc.delete();
        @(posedge clk); #1;
        a0 = int'(mem_addr);
        do_start(int'($urandom_range(0, DEPTH - 1)), 0, c);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_eq("t4_done_cyc", 128'(last_done_cyc), 128'(c + 1));
        check_eq("t4_addr_kept", 128'(mem_addr), 128'(a0));
        check_eq("t4_nbeats", 128'(beat_cyc.size()), 128'(0));

        // Reset mid-command after 5 of 12 beats
        n = beats_seen;
        do_start(32'h200, 12, c);
        wait_beats(n + 5, 100);
        rstn = 1'b0;
        #1;
        check_eq("mrst_busy", 128'(busy), 128'(0));
        check_eq("mrst_done", 128'(done), 128'(0));
        check_eq("mrst_valid", 128'(m_valid), 128'(0));
        check_eq("mrst_last", 128'(m_last), 128'(0));
        check_eq("mrst_data", 128'(m_data), 128'(0));
        check_eq("mrst_addr", 128'(mem_addr), 128'(0));
        exp_q.delete();
        done_q.delete();
        idle_from = 0;
        busy_from = 0;
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        beat_cyc.delete();
        do_start(32'h100, 2, c);
        wait_idle(50);
        check_eq("t5_nbeats", 128'(beat_cyc.size()), 128'(2));

        // Start while busy is ignored; start in the DONE cycle is accepted
        beat_cyc.delete();
        do_start(32'h050, 20, c);
        repeat (3) @(posedge clk);
        do_start(32'h2A0, 5, c2);
        n = 0;
        while (idle_from == NEVER && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq("t6_drain_seen", 128'(n < 200), 128'(1));
        do_start(32'h3F0, 6, c2);
        check_eq("t6_b2b_in_done", 128'(done_q.size() == 0 && idle_from == NEVER), 128'(1));
        wait_idle(100);
        check_eq("t6_nbeats", 128'(beat_cyc.size()), 128'(26));

        // Random commands with random backpressure
        for (int k = 0; k < 10; k++) begin
            rdy_rand = 1'($urandom);
            do_start(int'($urandom_range(0, DEPTH - 1)),
                     ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40)), c);
            if ($urandom_range(0, 1) == 1) do_start(int'($urandom_range(0, DEPTH - 1)), 7, c2);
            wait_idle(400);
        end
        rdy_rand = 1'b0;

        // Full-memory read from a non-zero base
        beat_cyc.delete();
        do_start(32'h1A5, DEPTH, c);
        wait_idle(DEPTH + 50);
        check_eq("t8_nbeats", 128'(beat_cyc.size()), 128'(DEPTH));
        check_eq("t8_done_cyc", 128'(idle_from), 128'(c + DEPTH + 3));

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uram_stream_reader.md
Name: uram_stream_reader

Overview:
- Read-side master for one port of the team's byte-write dual-port URAM: one write-enable bit per column, registered read with 1-cycle latency, read data updates only when the port's write enables are all zero.
- Takes a (base, length) command, issues sequential reads on the URAM port and emits the words as a valid/ready stream with a last flag.
- Credit-based 4-entry output FIFO absorbs the read latency and downstream backpressure. Sits between the URAM buffers and the NTT/DMA stream consumers.

Parameters:
AWIDTH, 10, URAM address width; depth = 2^AWIDTH words.
NUM_COL, 9, number of write-enable columns on the URAM port.
DWIDTH, 72, URAM and stream data width.

Ports:
clk  input  1  single clock, rising edge.
rstn  input  1  asynchronous active-low reset.
start  input  1  command strobe; accepted only when busy=0.
base_addr  input  AWIDTH  first word address, sampled with start.
len  input  AWIDTH+1  word count, 0..2^AWIDTH, sampled with start.
busy  output  1  high while a command is in progress.
done  output  1  one-cycle pulse when a command completes.
mem_we  output  NUM_COL  URAM write enables; constant 0.
mem_din  output  DWIDTH  URAM write data; constant 0.
mem_addr  output  AWIDTH  URAM address, registered.
mem_dout  input  DWIDTH  URAM registered read data.
m_data  output  DWIDTH  stream data (FIFO head).
m_valid  output  1  stream valid.
m_ready  input  1  stream ready.
m_last  output  1  marks the final word of a command.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE; FIFO flushed; in-flight pipe cleared.
  - Outputs: busy=0, done=0, m_valid=0, m_last=0, mem_addr=0, m_data=0.
  - Reset mid-command abandons it: no done, no further beats.
- mem_we and mem_din are tied to 0 at all times, so the URAM read register always updates.
- States:
  - IDLE:
    - start & len≠0 → RUN; latch addr=base_addr and remaining=len.
    - start & len=0 → DONE; no reads issued.
  - RUN: issues a read when remaining≠0 and credit allows, where credit means fifo_count + inflight < 4. On each issue:
    - mem_addr ← addr;
    - addr ← addr+1 mod 2^AWIDTH (0x3FF wraps to 0x000);
    - remaining ← remaining−1;
    - rd_pipe[0] ← 1, tagged last if remaining==1.
    - When remaining reaches 0 → DRAIN.
  - DRAIN: wait until the last-tagged word is accepted (m_valid & m_ready & m_last) → DONE.
  - DONE: one cycle. done=1, busy=0 → IDLE. A start in the DONE cycle is accepted.
- Read pipe, 2 stages:
  - issue edge drives mem_addr;
  - next edge registers mem_dout in the URAM;
  - the following edge writes mem_dout into the FIFO with its last tag.
  - inflight = number of set pipe stages.
- Latency: start high in cycle c with m_ready=1 gives first m_valid in cycle c+3.
- Throughput: 1 word/cycle with m_ready held high; a len=N command completes with done in cycle c+N+3.
- Backpressure:
  - the FIFO never overflows, because credit counts in-flight reads;
  - m_data, m_valid and m_last are stable while m_valid=1 and m_ready=0.
- busy=1 in RUN and DRAIN only. start while busy=1 is ignored; the sampled inputs are unchanged.
- len=2^AWIDTH reads every word exactly once, starting from base and wrapping.
- m_last is high on exactly one beat per command, the N-th.

Decomposition:
- Shared package: state encoding (IDLE/RUN/DRAIN/DONE) and the constant FIFO_DEPTH=4.
- One sub-module, stream_fifo4: 4-entry synchronous FIFO, DWIDTH+1 wide (data plus last tag), with count output, same clk and rstn.

Test Plan:
- base=0x010, len=4, m_ready=1, memory preloaded mem[i]=i → beats 0x10..0x13 on cycles c+3..c+6; m_last on 0x13; done at c+7.
- base=0x3FC, len=8 → addresses 0x3FC..0x3FF then 0x000..0x003 in order; exactly 8 beats, last on the word from 0x003.
- len=16 with m_ready toggled randomly 50% → all 16 words in order, no loss or duplication, outputs stable while stalled, mem_we=0 throughout.
- len=0 → done pulses at c+1; zero beats; mem_addr unchanged.
- Reset mid-command (rstn low after 5 of 12 beats) → all outputs 0 immediately; no done; a new command afterwards (base 0x100, len=2) completes normally.
- start pulsed while busy with different base/len → ignored; a back-to-back start in the DONE cycle is accepted and runs.
